// File: rtl/vga_timing_gen_param.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_param
//  Purpose  : Parametrised VGA timing generator. Produces H/V sync, blank,
//             sync-on-green and pixel clock for an arbitrary mode, plus a
//             look-ahead pixel request (oREQ/oX/oY) so that a pixel source
//             with a fixed read latency of REQ_LEAD cycles can feed the DAC.
//  Ports    : iCLK, iRST_N (asynchronous, asserted HIGH), iEN (timing enable)
//             iRed/iGreen/iBlue      pixel data from the source
//             oREQ/oX/oY             pixel request and its active column/row
//             oFRAME_START           pulse when outputs reflect H=0, V=0
//             oVGA_R/G/B, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC,
//             oVGA_CLK               board DAC interface
//  Option   : VGA_TEST_PATTERN_EN adds iPATTERN; when high the DAC shows
//             eight vertical colour bars instead of iRed/iGreen/iBlue.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module vga_timing_gen_param #(
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 12,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACT    = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACT    = 480,
  parameter int V_FRONT  = 10,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int REQ_LEAD = 2
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iEN,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               iPATTERN,
`endif
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oREQ,
  output logic [CNT_W-1:0]   oX,
  output logic [CNT_W-1:0]   oY,
  output logic               oFRAME_START,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLK
);

  localparam int c_hTot = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int c_vTot = V_SYNC + V_BACK + V_ACT + V_FRONT;

  localparam logic [CNT_W-1:0] c_hLast      = CNT_W'(c_hTot - 1);
  localparam logic [CNT_W-1:0] c_vLast      = CNT_W'(c_vTot - 1);
  localparam logic [CNT_W-1:0] c_hSyncEnd   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] c_vSyncEnd   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] c_hActStart  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] c_vActStart  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] c_hActEnd    = CNT_W'(H_SYNC + H_BACK + H_ACT);
  localparam logic [CNT_W-1:0] c_vActEnd    = CNT_W'(V_SYNC + V_BACK + V_ACT);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  // Look-ahead position that corresponds to counter position 0.
  localparam logic [CNT_W-1:0] c_laH0 = CNT_W'(REQ_LEAD % c_hTot);
  localparam logic [CNT_W-1:0] c_laV0 = CNT_W'((REQ_LEAD / c_hTot) % c_vTot);

  localparam logic c_hPol = (H_POL != 0);
  localparam logic c_vPol = (V_POL != 0);

  // Display position (drives DAC timing) and look-ahead position
  // (REQ_LEAD pixels ahead, drives the request path).
  logic [CNT_W-1:0] r_hCont, r_vCont;
  logic [CNT_W-1:0] r_laH, r_laV;
  logic [CNT_W-1:0] r_x, r_y;

  logic [CNT_W-1:0] w_hNext, w_vNext, w_laHNext, w_laVNext;
  logic             w_act, w_laAct;
  logic [CNT_W-1:0] w_laCol, w_laRow;
  logic [COLOR_W-1:0] w_red, w_green, w_blue;

  // --------------------------------------------------------------------------
  // Counter next-state (wrap exactly at H_TOT / V_TOT)
  // --------------------------------------------------------------------------
  always_comb begin
    w_hNext = (r_hCont == c_hLast) ? '0 : r_hCont + c_one;
    w_vNext = r_vCont;
    if (r_hCont == c_hLast) begin
      w_vNext = (r_vCont == c_vLast) ? '0 : r_vCont + c_one;
    end

    w_laHNext = (r_laH == c_hLast) ? '0 : r_laH + c_one;
    w_laVNext = r_laV;
    if (r_laH == c_hLast) begin
      w_laVNext = (r_laV == c_vLast) ? '0 : r_laV + c_one;
    end
  end

  assign w_act   = (r_hCont >= c_hActStart) && (r_hCont < c_hActEnd) &&
                   (r_vCont >= c_vActStart) && (r_vCont < c_vActEnd);
  assign w_laAct = (r_laH >= c_hActStart) && (r_laH < c_hActEnd) &&
                   (r_laV >= c_vActStart) && (r_laV < c_vActEnd);

  assign w_laCol = r_laH - c_hActStart;
  assign w_laRow = r_laV - c_vActStart;

  // Request is gated by iEN: while disabled the look-ahead position is held,
  // so the same position is requested once enable returns, never twice.
  assign oREQ = iEN & w_laAct;
  assign oX   = oREQ ? w_laCol : r_x;
  assign oY   = oREQ ? w_laRow : r_y;

  // --------------------------------------------------------------------------
  // Colour source selection
  // --------------------------------------------------------------------------
`ifdef VGA_TEST_PATTERN_EN
  localparam int c_barW = ((H_ACT / 8) > 0) ? (H_ACT / 8) : 1;

  logic [CNT_W-1:0] w_col, w_barRaw;
  logic [2:0]       w_bar;
  logic [2:0]       w_rgb;

  assign w_col    = r_hCont - c_hActStart;
  assign w_barRaw = w_col / CNT_W'(c_barW);
  // Clamp so a remainder column when H_ACT is not a multiple of 8 stays black.
  assign w_bar    = (w_barRaw > CNT_W'(7)) ? 3'd7 : w_barRaw[2:0];

  // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
  always_comb begin
    w_rgb = 3'b000;
    case (w_bar)
      3'd0:    w_rgb = 3'b111;
      3'd1:    w_rgb = 3'b110;
      3'd2:    w_rgb = 3'b011;
      3'd3:    w_rgb = 3'b010;
      3'd4:    w_rgb = 3'b101;
      3'd5:    w_rgb = 3'b100;
      3'd6:    w_rgb = 3'b001;
      default: w_rgb = 3'b000;
    endcase
  end

  assign w_red   = iPATTERN ? {COLOR_W{w_rgb[2]}} : iRed;
  assign w_green = iPATTERN ? {COLOR_W{w_rgb[1]}} : iGreen;
  assign w_blue  = iPATTERN ? {COLOR_W{w_rgb[0]}} : iBlue;
`else
  assign w_red   = iRed;
  assign w_green = iGreen;
  assign w_blue  = iBlue;
`endif

  // --------------------------------------------------------------------------
  // Position counters and held request coordinates
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST_N) begin
    if (iRST_N) begin
      r_hCont <= '0;
      r_vCont <= '0;
      r_laH   <= c_laH0;
      r_laV   <= c_laV0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (iEN) begin
      r_hCont <= w_hNext;
      r_vCont <= w_vNext;
      r_laH   <= w_laHNext;
      r_laV   <= w_laVNext;
      if (w_laAct) begin
        r_x <= w_laCol;
        r_y <= w_laRow;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered DAC-side outputs: reflect the position held one cycle earlier.
  // The source data arrives in the cycle whose display position is the
  // requested pixel, so it is captured here alongside BLANK.
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or posedge iRST_N) begin
    if (iRST_N) begin
      oVGA_H_SYNC  <= ~c_hPol;
      oVGA_V_SYNC  <= ~c_vPol;
      oVGA_BLANK   <= 1'b0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oFRAME_START <= 1'b0;
    end else if (iEN) begin
      oVGA_H_SYNC  <= (r_hCont < c_hSyncEnd) ? c_hPol : ~c_hPol;
      oVGA_V_SYNC  <= (r_vCont < c_vSyncEnd) ? c_vPol : ~c_vPol;
      oVGA_BLANK   <= w_act;
      oVGA_R       <= w_act ? w_red   : '0;
      oVGA_G       <= w_act ? w_green : '0;
      oVGA_B       <= w_act ? w_blue  : '0;
      oFRAME_START <= (r_hCont == '0) && (r_vCont == '0);
    end else begin
      oVGA_H_SYNC  <= ~c_hPol;
      oVGA_V_SYNC  <= ~c_vPol;
      oVGA_BLANK   <= 1'b0;
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oFRAME_START <= 1'b0;
    end
  end

  assign oVGA_SYNC = 1'b0;
  assign oVGA_CLK  = iCLK;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen_param
//  Purpose  : Scoreboard bench for vga_timing_gen_param in a 16x8 mode.
//             A source answers requests with {x,y} two enabled cycles later;
//             expected request coordinates and pixels are queued in raster
//             order and popped by the monitor as the DUT presents them.
//  Revision : 1.0 - initial bench
// ============================================================================
module tb_vga_timing_gen_param;

  localparam int HS = 4, HB = 2, HA = 8, HF = 2;
  localparam int VS = 2, VB = 1, VA = 4, VF = 1;
  localparam int HT = 16, VT = 8, FT = HT * VT;

  logic clk = 1'b0;
  logic rst, en;
  logic [7:0] red, green, blue;

  logic        req, fs, hs, vs, bl, sy, vck;
  logic [11:0] x, y;
  logic [7:0]  r, g, b;

  logic        pReq, pFs, pHs, pVs, pBl, pSy, pCk;
  logic [11:0] pX, pY;
  logic [7:0]  pR, pG, pB;

  always #5 clk = ~clk;

  vga_timing_gen_param #(
    .COLOR_W(8), .CNT_W(12),
    .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
    .H_POL(0), .V_POL(0), .REQ_LEAD(2)
  ) dut (
    .iCLK(clk), .iRST_N(rst), .iEN(en),
`ifdef VGA_TEST_PATTERN_EN
    .iPATTERN(1'b0),
`endif
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oREQ(req), .oX(x), .oY(y), .oFRAME_START(fs),
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
    .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_BLANK(bl),
    .oVGA_SYNC(sy), .oVGA_CLK(vck)
  );

  vga_timing_gen_param #(
    .COLOR_W(8), .CNT_W(12),
    .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_FRONT(VF),
    .H_POL(1), .V_POL(1), .REQ_LEAD(2)
  ) dutP (
    .iCLK(clk), .iRST_N(rst), .iEN(en),
`ifdef VGA_TEST_PATTERN_EN
    .iPATTERN(1'b0),
`endif
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oREQ(pReq), .oX(pX), .oY(pY), .oFRAME_START(pFs),
    .oVGA_R(pR), .oVGA_G(pG), .oVGA_B(pB),
    .oVGA_H_SYNC(pHs), .oVGA_V_SYNC(pVs), .oVGA_BLANK(pBl),
    .oVGA_SYNC(pSy), .oVGA_CLK(pCk)
  );

  int nChecks = 0;
  int nFails  = 0;

  logic [15:0] reqQ[$];
  logic [15:0] pixQ[$];

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected raster order for one frame: (0,0)..(7,3).
  task automatic pushFrames(input int n);
    for (int f = 0; f < n; f++)
      for (int yy = 0; yy < VA; yy++)
        for (int xx = 0; xx < HA; xx++) begin
          reqQ.push_back({8'(xx), 8'(yy)});
          pixQ.push_back({8'(xx), 8'(yy)});
        end
  endtask

  // Whether the DUT counters advanced on the most recent clock edge.
  logic edgeAdv = 1'b0;
  always @(posedge clk) edgeAdv <= en & ~rst;

  // Pixel source: a delay line that shifts only when the DUT position
  // advanced, so data lands REQ_LEAD positions after the request.
  logic [16:0] s0, s1, s2;
  always @(negedge clk) begin
    if (rst) begin
      s0 = '0; s1 = '0; s2 = '0;
      red = 8'h00; green = 8'h00; blue = 8'h00;
    end else begin
      if (edgeAdv) begin
        s2 = s1;
        s1 = s0;
      end
      s0    = {req, x[7:0], y[7:0]};
      red   = s2[16] ? s2[15:8] : 8'h00;
      green = s2[16] ? s2[7:0]  : 8'h00;
      blue  = s2[16] ? 8'hA5    : 8'h00;
    end
  end

  // Monitor: independent position model plus scoreboard pops.
  int  mOff = FT - 1;
  bit  frameValid = 1'b0;
  int  cntHs, cntVs, cntBl, cntReq, cntHsP, cntVsP;
  always @(negedge clk) begin
    int h, v;
    logic expHs, expVs, expBl;
    logic [15:0] e;
    if (rst) begin
      mOff = FT - 1;
      frameValid = 1'b0;
      cntHs = 0; cntVs = 0; cntBl = 0; cntReq = 0; cntHsP = 0; cntVsP = 0;
      check("rst blank", bl, 0);
      check("rst hsync", hs, 1);
      check("rst vsync", vs, 1);
      check("rst hsyncP", pHs, 0);
      check("rst vsyncP", pVs, 0);
      check("rst req", req, 0);
      check("rst frameStart", fs, 0);
      check("rst red", r, 0);
    end else begin
      if (req) begin
        cntReq++;
        if (reqQ.size() == 0) check("reqQ underflow", 1, 0);
        else begin
          e = reqQ.pop_front();
          check("req X", x, e[15:8]);
          check("req Y", y, e[7:0]);
        end
      end
      if (edgeAdv) begin
        mOff = (mOff + 1) % FT;
        h = mOff % HT;
        v = mOff / HT;
        if (mOff == 0) begin
          if (frameValid) begin
            check("frame hsync low", cntHs, 32);
            check("frame vsync low", cntVs, 32);
            check("frame blank high", cntBl, 32);
            check("frame req pulses", cntReq, 32);
            check("frame hsyncP high", cntHsP, 32);
            check("frame vsyncP high", cntVsP, 32);
          end
          frameValid = 1'b1;
          cntHs = 0; cntVs = 0; cntBl = 0; cntReq = 0; cntHsP = 0; cntVsP = 0;
        end
        expHs = (h < HS) ? 1'b0 : 1'b1;
        expVs = (v < VS) ? 1'b0 : 1'b1;
        expBl = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        check("hsync", hs, expHs);
        check("vsync", vs, expVs);
        check("hsyncP", pHs, !expHs);
        check("vsyncP", pVs, !expVs);
        check("blank", bl, expBl);
        check("blankP", pBl, expBl);
        check("frameStart", fs, (mOff == 0));
        if (!hs) cntHs++;
        if (!vs) cntVs++;
        if (bl) cntBl++;
        if (pHs) cntHsP++;
        if (pVs) cntVsP++;
        if (bl) begin
          if (pixQ.size() == 0) check("pixQ underflow", 1, 0);
          else begin
            e = pixQ.pop_front();
            check("pix red=col", r, e[15:8]);
            check("pix green=row", g, e[7:0]);
            check("pix blue", b, 8'hA5);
          end
        end else begin
          check("blanked red", r, 0);
          check("blanked green", g, 0);
          check("blanked blue", b, 0);
        end
      end else begin
        check("paused blank", bl, 0);
        check("paused hsync", hs, 1);
        check("paused vsync", vs, 1);
        check("paused frameStart", fs, 0);
        check("paused red", r, 0);
      end
    end
  end

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((pixQ.size() != 0 || reqQ.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("pixQ drained", pixQ.size(), 0);
    check("reqQ drained", reqQ.size(), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    en  = 1'b1;
    pushFrames(2);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("first frameStart", fs, 1);
    check("vga clk", vck, 1);
    check("sync-on-green", sy, 0);
    waitDrain(400);

    // Enable drop mid active line.
    pushFrames(1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req && x == 12'd3) && n < 400);
    check("saw req x=3", (req && x == 12'd3), 1);
    @(posedge clk); #2 en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pause req", req, 0);
      check("pause held X", x, 3);
      @(posedge clk);
      if (i == 4) #2 en = 1'b1;
    end
    waitDrain(300);

    // Asynchronous reset when counters hold H=10, V=3.
    pushFrames(1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (mOff != 3 * HT + 8 && n < 400);
    check("reached H10 V3", mOff, 3 * HT + 8);
    #2 rst = 1'b1;
    #1;
    check("async rst blank", bl, 0);
    check("async rst hsync", hs, 1);
    check("async rst vsync", vs, 1);
    check("async rst hsyncP", pHs, 0);
    check("async rst red", r, 0);
    check("async rst req", req, 0);
    check("async rst X", x, 0);
    check("async rst Y", y, 0);
    check("async rst frameStart", fs, 0);
    reqQ.delete();
    pixQ.delete();
    repeat (3) @(posedge clk);
    pushFrames(1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst frameStart", fs, 1);
    check("post-rst hsync", hs, 0);
    check("post-rst blank", bl, 0);
    waitDrain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", nFails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
